// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the updown_counter family.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // MAX_COUNT is carried one bit wider than the counter so that 2**WIDTH and
  // above can be detected; the check covers widths up to 127 bits.
  function automatic bit max_count_legal(input int unsigned width,
                                         input logic [127:0] max_count);
    return (width >= 1) && (width <= 127) && ((max_count >> width) == '0);
  endfunction

endpackage

// File: rtl/updown_counter_formal.sv
// Property harness around updown_counter: every edge is checked against the
// inputs and state sampled on the previous edge, once a reset has been seen.
module updown_counter_formal
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH:0]   MAX_COUNT = {1'b0, {WIDTH{1'b1}}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr
);

  localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] y, p_y, p_load_val, exp_y;
  logic             tc, ovf;
  logic             past_valid_q;
  logic             p_rst, p_en, p_up, p_load, p_ovf_clr, p_ovf, p_tc, p_bound;

  updown_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .SATURATE(SATURATE)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .y(y), .tc(tc), .ovf(ovf)
  );

  always_comb begin
    exp_y   = p_y;
    p_bound = p_en & ~p_load & ~p_rst & (p_up ? (p_y == MAX_Q) : (p_y == '0));
    if (p_load) begin
      exp_y = (p_load_val > MAX_Q) ? MAX_Q : p_load_val;
    end else if (p_en && p_up) begin
      exp_y = (p_y == MAX_Q) ? (SATURATE ? MAX_Q : '0) : p_y + WIDTH'(1);
    end else if (p_en) begin
      exp_y = (p_y == '0) ? (SATURATE ? '0 : MAX_Q) : p_y - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    past_valid_q <= past_valid_q | rst;
    p_rst        <= rst;
    p_en         <= en;
    p_up         <= up;
    p_load       <= load;
    p_load_val   <= load_val;
    p_ovf_clr    <= ovf_clr;
    p_y          <= y;
    p_ovf        <= ovf;
    p_tc         <= tc;
    if (past_valid_q) begin
      a_in_range: assert (y <= MAX_Q);
      a_tc_event: assert (p_tc == p_bound);
      if (p_rst) begin
        a_reset: assert (y == '0 && !ovf);
      end else begin
        a_next_y:   assert (y == exp_y);
        a_next_ovf: assert (ovf == (p_tc | (p_ovf & ~p_ovf_clr)));
        a_monotone: assert (!p_ovf || p_ovf_clr || ovf);
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with clamped parallel load, programmable terminal value,
// wrap or saturate at the bounds, a terminal-count strobe and a sticky overflow.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH:0]   MAX_COUNT = {1'b0, {WIDTH{1'b1}}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             ovf
);

  if (!max_count_legal(WIDTH, 128'(MAX_COUNT))) begin : g_illegal_max_count
    $error("updown_counter: MAX_COUNT must be below 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero, bound_evt;

  assign at_max    = (y_q == MAX_Q);
  assign at_zero   = (y_q == '0);
  assign bound_evt = en & ~load & ~rst & ((up == CNT_UP) ? at_max : at_zero);

  // Bounds are compared before stepping so nothing ever leaves WIDTH bits and
  // the count stays modulo MAX_COUNT+1.
  always_comb begin
    // NOTE: defaults first so every path assigns y_d/ovf_d and no latch is inferred.
    y_d   = y_q;
    ovf_d = ovf_q;
    if (load) begin
      y_d = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (en) begin
      if (up == CNT_UP) begin
        if (at_max) y_d = SATURATE ? MAX_Q : '0;
        else        y_d = y_q + WIDTH'(1);
      end else begin
        if (at_zero) y_d = SATURATE ? '0 : MAX_Q;
        else         y_d = y_q - WIDTH'(1);
      end
    end
    if (bound_evt)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign y   = y_q;
  assign tc  = bound_evt;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter at WIDTH=4, MAX_COUNT=9, covering the wrap
// and saturate builds side by side with shared stimulus.
module tb_updown_counter;

  localparam int unsigned    W   = 4;
  localparam logic [W:0]     MAX = 5'd9;

  typedef struct {
    bit         sat;
    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic       ovf_clr;
    logic       exp_tc;
    logic [3:0] exp_y;
    logic       exp_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, ovf_clr = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] y_wrap, y_sat;
  logic       tc_wrap, tc_sat, ovf_wrap, ovf_sat;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .y(y_wrap), .tc(tc_wrap), .ovf(ovf_wrap)
  );

  updown_counter #(.WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .y(y_sat), .tc(tc_sat), .ovf(ovf_sat)
  );

  updown_counter_formal #(.WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1'b0)) u_fv_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr)
  );

  updown_counter_formal #(.WIDTH(W), .MAX_COUNT(MAX), .SATURATE(1'b1)) u_fv_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t v(input bit sat, input logic r, input logic e, input logic u,
                             input logic l, input logic [3:0] lv, input logic c,
                             input logic t, input logic [3:0] ey, input logic eo);
    vec_t x;
    x.sat = sat; x.rst = r; x.en = e; x.up = u; x.load = l; x.load_val = lv;
    x.ovf_clr = c; x.exp_tc = t; x.exp_y = ey; x.exp_ovf = eo;
    return x;
  endfunction

  // tc is checked before the edge with the inputs applied; y/ovf after it.
  task automatic apply(input vec_t x, input int idx);
    @(negedge clk);
    rst = x.rst; en = x.en; up = x.up; load = x.load;
    load_val = x.load_val; ovf_clr = x.ovf_clr;
    #1;
    check($sformatf("v%0d_tc", idx), x.sat ? tc_sat : tc_wrap, x.exp_tc);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_y", idx), x.sat ? y_sat : y_wrap, x.exp_y);
    check($sformatf("v%0d_ovf", idx), x.sat ? ovf_sat : ovf_wrap, x.exp_ovf);
  endtask

  initial begin
    int found;

    // Wrap build: reset (load ignored), then 12 up steps through the 9->0 wrap.
    vecs.push_back(v(0, 1, 1, 1, 1, 4'd5, 0,  0, 4'd0, 0));
    for (int i = 0; i < 12; i++)
      vecs.push_back(v(0, 0, 1, 1, 0, 4'd0, 0,  i == 9, 4'((i + 1) % 10), i >= 9));
    // Load 2 (clearing ovf), then count down through 0 -> 9.
    vecs.push_back(v(0, 0, 0, 0, 1, 4'd2, 1,  0, 4'd2, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4'd0, 0,  0, 4'd1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4'd0, 0,  0, 4'd0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4'd0, 0,  1, 4'd9, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 4'd0, 0,  0, 4'd8, 1));
    // Direction flips with no dead cycle.
    vecs.push_back(v(0, 0, 1, 1, 0, 4'd0, 0,  0, 4'd9, 1));
    vecs.push_back(v(0, 0, 1, 1, 0, 4'd0, 0,  1, 4'd0, 1));
    // Load clamp beats en; reset beats load.
    vecs.push_back(v(0, 0, 1, 1, 1, 4'd15, 0, 0, 4'd9, 1));
    vecs.push_back(v(0, 1, 0, 0, 1, 4'd5, 0,  0, 4'd0, 0));
    // Set wins over clear at the wrap edge, then clear alone.
    vecs.push_back(v(0, 0, 0, 0, 1, 4'd9, 0,  0, 4'd9, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 4'd0, 1,  1, 4'd0, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 4'd0, 1,  0, 4'd0, 0));
    // Hold, down-wrap racing a clear, load keeps ovf, load with clear drops it.
    vecs.push_back(v(0, 0, 0, 0, 0, 4'd0, 0,  0, 4'd0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4'd0, 1,  1, 4'd9, 1));
    vecs.push_back(v(0, 0, 1, 0, 1, 4'd3, 0,  0, 4'd3, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 4'd4, 1,  0, 4'd4, 0));
    // Saturate build: hold at 9 going up and at 0 going down.
    vecs.push_back(v(1, 1, 0, 0, 0, 4'd0, 0,  0, 4'd0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 4'd8, 0,  0, 4'd8, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 4'd0, 0,  0, 4'd9, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 4'd0, 0,  1, 4'd9, 1));
    vecs.push_back(v(1, 0, 1, 1, 0, 4'd0, 0,  1, 4'd9, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 4'd0, 1,  0, 4'd0, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 4'd0, 0,  1, 4'd0, 1));
    vecs.push_back(v(1, 0, 1, 1, 0, 4'd0, 0,  0, 4'd1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 4'd15, 0, 0, 4'd9, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // tc while rst is held must stay low even at a bound.
    @(negedge clk);
    rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    #1;
    check("tc_during_rst", tc_wrap, 1'b0);
    @(posedge clk);

    // From a load of 5, tc must rise exactly when y reaches 9 (bounded search).
    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd5; ovf_clr = 1'b1;
    @(posedge clk);
    found = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      load = 1'b0; ovf_clr = 1'b0; en = 1'b1; up = 1'b1;
      #1;
      if (tc_wrap) begin
        found = k;
        break;
      end
      @(posedge clk);
    end
    check("tc_search_steps", 32'(found), 32'd4);
    check("tc_search_y", y_wrap, 4'd9);
    check("tc_search_ovf", ovf_wrap, 1'b0);
    @(posedge clk);
    #1;
    check("tc_search_wrap_y", y_wrap, 4'd0);
    check("tc_search_wrap_ovf", ovf_wrap, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
